// File: rtl/pixel_pkg.sv
// Shared pixel and 3x3 window types for the image pipeline.
// window_t is indexed [row][col]; [0][0] is the top-left pixel.
package pixel_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_SIZE = 3;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [WIN_SIZE-1:0][WIN_SIZE-1:0] window_t;

endpackage

// File: rtl/axis_if.sv
// Valid/ready stream interface carrying one beat of type T.
// Ports: data/vld from master, rdy from slave.
interface axis_if #(
    parameter type T = logic
);

    logic vld;
    logic rdy;
    T     data;

    modport master (output vld, output data, input rdy);
    modport slave  (input vld, input data, output rdy);

endinterface

// File: rtl/line_buf.sv
// Line buffer: single write port, asynchronous read, no reset.
// Ports: clk_i, we_i, addr_i (shared rd/wr), wdata_i, rdata_o.
module line_buf #(
    parameter int  DEPTH = 1024,
    parameter type T     = logic [7:0],
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  T              wdata_i,
    output T              rdata_o
);

    T mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_window.sv
// 3x3 window builder: two line buffers plus a 3-column shift register,
// one window per interior pixel, one output register stage.
// Ports: clk, rst (async, active-low), axis_i (pixels), line/done
// (row/image end strobes), axis_o (windows), line_o, done_o.
// Optional: LINE_WINDOW_OVF_CHECK_EN adds sticky output ovf.
module line_window
    import pixel_pkg::*;
#(
    parameter int MAX_WIDTH = 1024,
    parameter int COL_W     = $clog2(MAX_WIDTH),
    parameter int ROW_W     = 16
) (
    input  logic   clk,
    input  logic   rst,
    axis_if.slave  axis_i,
    input  logic   line,
    input  logic   done,
    axis_if.master axis_o,
    output logic   line_o,
    output logic   done_o
`ifdef LINE_WINDOW_OVF_CHECK_EN
    ,
    output logic   ovf
`endif
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAX_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = '1;

    pixel_t pix;
    pixel_t top_rd;
    pixel_t mid_rd;

    logic acc;
    logic line_e;
    logic at_last;
    logic keep;
    logic emit;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             sat_q, sat_d;
    window_t          sr_q, sr_d;

    logic    vld_q, vld_d;
    window_t data_q, data_d;
    logic    line_q, line_d;
    logic    done_q, done_d;

    assign pix        = axis_i.data;
    assign axis_i.rdy = !vld_q || axis_o.rdy;
    assign acc        = axis_i.vld && axis_i.rdy;
    // done alone still closes the row
    assign line_e     = line || done;
    assign at_last    = (col_q == COL_LAST);
    // sat_q marks pixels past the buffer width: they are dropped
    assign keep       = acc && !sat_q;
    assign emit       = keep && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    line_buf #(
        .DEPTH (MAX_WIDTH),
        .T     (pixel_t)
    ) lb_top (
        .clk_i   (clk),
        .we_i    (keep),
        .addr_i  (col_q),
        .wdata_i (mid_rd),
        .rdata_o (top_rd)
    );

    line_buf #(
        .DEPTH (MAX_WIDTH),
        .T     (pixel_t)
    ) lb_mid (
        .clk_i   (clk),
        .we_i    (keep),
        .addr_i  (col_q),
        .wdata_i (pix),
        .rdata_o (mid_rd)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        sat_d = sat_q;
        if (acc) begin
            if (done) begin
                col_d = '0;
                row_d = '0;
                sat_d = 1'b0;
            end else if (line) begin
                col_d = '0;
                sat_d = 1'b0;
                if (row_q != ROW_LAST) begin
                    row_d = row_q + ROW_W'(1);
                end
            end else if (at_last) begin
                sat_d = 1'b1;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Left shift; the two older columns are zeroed at row start.
    always_comb begin
        sr_d = sr_q;
        if (keep) begin
            for (int r = 0; r < WIN_SIZE; r++) begin
                sr_d[r][0] = (col_q == '0) ? '0 : sr_q[r][1];
                sr_d[r][1] = (col_q == '0) ? '0 : sr_q[r][2];
            end
            sr_d[0][2] = top_rd;
            sr_d[1][2] = mid_rd;
            sr_d[2][2] = pix;
        end
    end

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        line_d = line_q;
        done_d = done_q;
        if (axis_o.rdy) begin
            vld_d = 1'b0;
        end
        if (emit) begin
            vld_d  = 1'b1;
            data_d = sr_d;
            line_d = line_e;
            done_d = done;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q  <= '0;
            row_q  <= '0;
            sat_q  <= 1'b0;
            sr_q   <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            line_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            sat_q  <= sat_d;
            sr_q   <= sr_d;
            vld_q  <= vld_d;
            data_q <= data_d;
            line_q <= line_d;
            done_q <= done_d;
        end
    end

    assign axis_o.vld  = vld_q;
    assign axis_o.data = data_q;
    assign line_o      = line_q;
    assign done_o      = done_q;

`ifdef LINE_WINDOW_OVF_CHECK_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (acc && at_last && !line_e) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_line_window.sv
// Bench for line_window: directed table for a 4x4 frame, then random
// frames with stalls and gaps checked against an arithmetic window model.
`timescale 1ns/1ps
module tb_line_window;
    import pixel_pkg::*;

    localparam int MAXW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic line = 1'b0;
    logic done = 1'b0;
    logic line_o;
    logic done_o;
`ifdef LINE_WINDOW_OVF_CHECK_EN
    logic ovf;
`endif

    axis_if #(.T(pixel_t))  in_if ();
    axis_if #(.T(window_t)) out_if ();

    always #5 clk = ~clk;

    line_window #(
        .MAX_WIDTH (MAXW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .axis_i (in_if),
        .line   (line),
        .done   (done),
        .axis_o (out_if),
        .line_o (line_o),
        .done_o (done_o)
`ifdef LINE_WINDOW_OVF_CHECK_EN
        ,
        .ovf    (ovf)
`endif
    );

    typedef struct {
        window_t win;
        bit      l;
        bit      d;
    } beat_t;

    typedef struct {
        pixel_t  p;
        bit      l;
        bit      d;
        bit      ev;
        window_t ew;
        bit      el;
        bit      ed;
    } vec_t;

    beat_t  exp_q[$];
    vec_t   tbl[16];
    pixel_t img[64];
    int     vectors  = 0;
    int     errors   = 0;
    int     rdy_mode = 0;
    bit     mon_en   = 0;
    bit     gaps     = 0;
    bit     ovf_exp  = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic window_t w9(int a, int b, int c, int d, int e,
                                   int f, int g, int h, int i);
        window_t x;
        x[0][0] = pixel_t'(a); x[0][1] = pixel_t'(b); x[0][2] = pixel_t'(c);
        x[1][0] = pixel_t'(d); x[1][1] = pixel_t'(e); x[1][2] = pixel_t'(f);
        x[2][0] = pixel_t'(g); x[2][1] = pixel_t'(h); x[2][2] = pixel_t'(i);
        return x;
    endfunction

    // Every interior pixel inside the buffer width yields one window.
    task automatic model_push(int w, int h);
        int wc;
        wc = (w < MAXW) ? w : MAXW;
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < wc; c++) begin
                beat_t b;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        b.win[i][j] = img[(r - 2 + i) * w + (c - 2 + j)];
                b.l = (c == w - 1);
                b.d = (c == w - 1) && (r == h - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic monitor();
        bit      st;
        window_t pd;
        bit      pl;
        bit      pdn;
        st = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                st = 0;
            end else begin
                if (st) begin
                    chk("hold_vld", out_if.vld, 1);
                    chk("hold_data", out_if.data, pd);
                    chk("hold_line", line_o, pl);
                    chk("hold_done", done_o, pdn);
                end
                st = 0;
                if (out_if.vld && !out_if.rdy) begin
                    chk("stall_in_rdy", in_if.rdy, 0);
                    st  = 1;
                    pd  = out_if.data;
                    pl  = line_o;
                    pdn = done_o;
                end
                if (out_if.vld && out_if.rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        beat_t b;
                        b = exp_q.pop_front();
                        chk("win_data", out_if.data, b.win);
                        chk("win_line", line_o, b.l);
                        chk("win_done", done_o, b.d);
                    end
                end
            end
        end
    endtask

    task automatic rdy_drv();
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_if.rdy = 1'b1;
                1:       out_if.rdy = 1'($urandom);
                default: out_if.rdy = 1'b0;
            endcase
        end
    endtask

    task automatic send_pix(pixel_t p, bit l, bit d);
        bit ok;
        ok = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                in_if.vld  = 1'b0;
                in_if.data = pixel_t'($urandom);
                line       = 1'($urandom);
                done       = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        in_if.vld  = 1'b1;
        in_if.data = p;
        line       = l;
        done       = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            ok = in_if.rdy;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        in_if.vld = 1'b0;
        line      = 1'b0;
        done      = 1'b0;
    endtask

    task automatic send_img(int w, int h, int n, bit dnl, bit rnd);
        for (int k = 0; k < w * h; k++)
            img[k] = rnd ? pixel_t'($urandom) : pixel_t'(k);
        if (n == w * h) model_push(w, h);
        for (int k = 0; k < n; k++) begin
            bit lc;
            bit last;
            lc   = (k % w) == w - 1;
            last = (k == w * h - 1);
            send_pix(img[k], lc && !(last && dnl), last);
            if ((k % w) >= MAXW - 1 && !lc && !last) ovf_exp = 1;
`ifdef LINE_WINDOW_OVF_CHECK_EN
            chk("ovf", ovf, ovf_exp);
`endif
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_vld", out_if.vld, 0);
        chk("rst_line_o", line_o, 0);
        chk("rst_done_o", done_o, 0);
        chk("rst_in_rdy", in_if.rdy, 1);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        ovf_exp = 0;
        exp_q.delete();
`ifdef LINE_WINDOW_OVF_CHECK_EN
        chk("rst_ovf", ovf, 0);
`endif
        mon_en = 1;
    endtask

    initial begin
        int w;
        int h;
        in_if.vld  = 1'b0;
        in_if.data = '0;
        out_if.rdy = 1'b1;
        fork
            monitor();
            rdy_drv();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_vld", out_if.vld, 0);
        chk("reset_line_o", line_o, 0);
        chk("reset_done_o", done_o, 0);
        chk("reset_in_rdy", in_if.rdy, 1);
`ifdef LINE_WINDOW_OVF_CHECK_EN
        chk("reset_ovf", ovf, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 16; k++)
            tbl[k] = '{pixel_t'(k), (k % 4) == 3, k == 15, 0, '0, 0, 0};
        tbl[10] = '{pixel_t'(10), 0, 0, 1, w9(0, 1, 2, 4, 5, 6, 8, 9, 10), 0, 0};
        tbl[11] = '{pixel_t'(11), 1, 0, 1, w9(1, 2, 3, 5, 6, 7, 9, 10, 11), 1, 0};
        tbl[14] = '{pixel_t'(14), 0, 0, 1, w9(4, 5, 6, 8, 9, 10, 12, 13, 14), 0, 0};
        tbl[15] = '{pixel_t'(15), 1, 1, 1, w9(5, 6, 7, 9, 10, 11, 13, 14, 15), 1, 1};

        for (int k = 0; k < 16; k++) begin
            in_if.vld  = 1'b1;
            in_if.data = tbl[k].p;
            line       = tbl[k].l;
            done       = tbl[k].d;
            @(posedge clk);
            #1;
            chk($sformatf("tbl_vld[%0d]", k), out_if.vld, tbl[k].ev);
            if (tbl[k].ev) begin
                chk($sformatf("tbl_data[%0d]", k), out_if.data, tbl[k].ew);
                chk($sformatf("tbl_line[%0d]", k), line_o, tbl[k].el);
                chk($sformatf("tbl_done[%0d]", k), done_o, tbl[k].ed);
            end
        end
        in_if.vld = 1'b0;
        line      = 1'b0;
        done      = 1'b0;
        @(posedge clk);
        #1;

        mon_en   = 1;
        rdy_mode = 1;
        gaps     = 1;
        repeat (3) begin
            send_img(4, 4, 16, 0, 0);
            drain();
        end
        send_img(4, 4, 16, 0, 1);
        drain();

        send_img(2, 5, 10, 0, 0);
        send_img(5, 2, 10, 0, 0);
        send_img(3, 3, 9, 0, 0);
        drain();

        send_img(3, 3, 9, 1, 0);
        drain();

        for (int n = 0; n < 12; n++) begin
            w = $urandom_range(1, MAXW + 2);
            h = $urandom_range(1, 5);
            send_img(w, h, w * h, 0, 1);
        end
        drain();

        rdy_mode = 0;
        gaps     = 0;
        send_img(4, 4, 6, 0, 0);
        do_reset();
        send_img(3, 3, 9, 0, 0);
        drain();

        rdy_mode = 2;
        @(posedge clk);
        #1;
        send_img(4, 4, 11, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("held_vld", out_if.vld, 1);
        do_reset();
        rdy_mode = 1;
        gaps     = 1;
        send_img(3, 3, 9, 0, 1);
        drain();

        send_img(10, 3, 30, 0, 1);
        drain();
        send_img(3, 3, 9, 0, 1);
        drain();
        do_reset();
        send_img(4, 3, 12, 0, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
